// File: rtl/dilation_pkg.sv
// Shared types and constants for the dilation frame sequencer and its window datapath.
package dilation_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int COORD_W = 13;
    localparam int FED_W   = 20;

    localparam logic [15:0] DEF_PX_PER_ROW     = 16'd520;
    localparam logic [15:0] DEF_ROWS_PER_FRAME = 16'd390;

    function automatic logic on_border(
        input logic [COORD_W-1:0] col,
        input logic [COORD_W-1:0] row,
        input logic [15:0]        w,
        input logic [15:0]        h
    );
        return (col == '0) || (col == COORD_W'(w - 16'd1)) ||
               (row == '0) || (row == COORD_W'(h - 16'd1));
    endfunction

endpackage

// File: rtl/dil_coord_counter.sv
// Raster column/row counter with wrap, used for output tags and border detection.
module dil_coord_counter
    import dilation_pkg::*;
#(
    parameter logic [15:0] PX_PER_ROW     = DEF_PX_PER_ROW,
    parameter logic [15:0] ROWS_PER_FRAME = DEF_ROWS_PER_FRAME
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               ena,
    output logic [COORD_W-1:0] col,
    output logic [COORD_W-1:0] row
);

    localparam logic [COORD_W-1:0] COL_LAST = COORD_W'(PX_PER_ROW - 16'd1);
    localparam logic [COORD_W-1:0] ROW_LAST = COORD_W'(ROWS_PER_FRAME - 16'd1);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            col <= '0;
            row <= '0;
        end else if (clr) begin
            col <= '0;
            row <= '0;
        end else if (ena) begin
            if (col == COL_LAST) begin
                col <= '0;
                row <= (row == ROW_LAST) ? '0 : row + COORD_W'(1);
            end else begin
                col <= col + COORD_W'(1);
            end
        end
    end

endmodule

// File: rtl/dilation_stream_ctrl.sv
// Frame sequencer for the 3x3 dilation window: input handshake, row-buffer flush, tagged output.
// Optional DIL_BORDER_MASK_EN forces border outputs to zero.
module dilation_stream_ctrl
    import dilation_pkg::*;
#(
    parameter logic [15:0] PX_PER_ROW     = DEF_PX_PER_ROW,
    parameter logic [15:0] ROWS_PER_FRAME = DEF_ROWS_PER_FRAME
) (
    input  logic               CLK100MHZ,
    input  logic               btn_reset,
    input  logic               start,
    input  logic               in_valid,
    input  logic               in_px,
    output logic               in_ready,
    input  logic               kernel_px,
    output logic               win_px,
    output logic               win_ena,
    output logic               win_reset,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_px,
    output logic [COORD_W-1:0] out_col,
    output logic [COORD_W-1:0] out_row,
    output logic               busy,
    output logic               frame_done
);

    localparam int unsigned PIX_N = 32'(PX_PER_ROW) * 32'(ROWS_PER_FRAME);
    localparam logic [FED_W-1:0] PRIME_N  = FED_W'(32'(PX_PER_ROW) + 32'd1);
    localparam logic [FED_W-1:0] LAST_PX  = FED_W'(PIX_N - 32'd1);
    localparam logic [FED_W-1:0] LAST_ADV = FED_W'(PIX_N + 32'(PX_PER_ROW));

    state_t           state;
    state_t           state_nxt;
    logic [FED_W-1:0] fed;
    logic             free;
    logic             adv;
    logic             load;
    logic             out_hs;
    logic             start_frame;
    logic             px_next;

    assign free        = !out_valid || out_ready;
    assign out_hs      = out_valid && out_ready;
    assign start_frame = (state == ST_IDLE) && start;
    // The first W+1 advances only prime the row buffers; no centred result exists yet.
    assign load        = adv && (fed >= PRIME_N);

    always_ff @(posedge CLK100MHZ or posedge btn_reset) begin
        if (btn_reset) state <= ST_IDLE;
        else           state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (start) state_nxt = ST_RUN;
            ST_RUN:   if (adv && (fed == LAST_PX)) state_nxt = ST_FLUSH;
            ST_FLUSH: if (adv && (fed == LAST_ADV)) state_nxt = ST_DONE;
            ST_DONE:  if (free) state_nxt = ST_IDLE;
            default:  state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = 1'b0;
        adv       = 1'b0;
        win_px    = 1'b0;
        win_reset = 1'b0;
        busy      = 1'b1;
        case (state)
            ST_IDLE: begin
                win_reset = 1'b1;
                busy      = 1'b0;
            end
            ST_RUN: begin
                in_ready = free;
                adv      = free && in_valid;
                win_px   = in_px;
            end
            ST_FLUSH: begin
                adv = free;
            end
            ST_DONE: begin
                win_reset = free;
            end
            default: begin
                win_reset = 1'b1;
                busy      = 1'b0;
            end
        endcase
    end

    assign win_ena = adv;

`ifdef DIL_BORDER_MASK_EN
    logic [COORD_W-1:0] ld_col;
    logic [COORD_W-1:0] ld_row;

    // Tracks the coordinate of the result being loaded, one step ahead of out_col/out_row.
    dil_coord_counter #(
        .PX_PER_ROW     (PX_PER_ROW),
        .ROWS_PER_FRAME (ROWS_PER_FRAME)
    ) u_load_coord (
        .clk (CLK100MHZ),
        .rst (btn_reset),
        .clr (start_frame),
        .ena (load),
        .col (ld_col),
        .row (ld_row)
    );

    assign px_next = kernel_px && !on_border(ld_col, ld_row, PX_PER_ROW, ROWS_PER_FRAME);
`else
    assign px_next = kernel_px;
`endif

    dil_coord_counter #(
        .PX_PER_ROW     (PX_PER_ROW),
        .ROWS_PER_FRAME (ROWS_PER_FRAME)
    ) u_out_coord (
        .clk (CLK100MHZ),
        .rst (btn_reset),
        .clr (start_frame),
        .ena (out_hs),
        .col (out_col),
        .row (out_row)
    );

    always_ff @(posedge CLK100MHZ or posedge btn_reset) begin
        if (btn_reset) begin
            fed        <= '0;
            out_valid  <= 1'b0;
            out_px     <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= (state == ST_DONE) && free;
            if (start_frame) begin
                fed <= '0;
            end else if (adv) begin
                fed <= fed + FED_W'(1);
            end
            // A load in the same cycle as a consume keeps the slot full with the new result.
            if (load) begin
                out_valid <= 1'b1;
                out_px    <= px_next;
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_dilation_stream_ctrl.sv
// Scoreboard bench for dilation_stream_ctrl with a linear-row-buffer window model.
`timescale 1ns/1ps
module tb_dilation_stream_ctrl;

    localparam int W = 8;
    localparam int H = 4;
    localparam int N = W * H;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_px;
    logic        in_ready;
    logic        kernel_px;
    logic        win_px;
    logic        win_ena;
    logic        win_reset;
    logic        out_valid;
    logic        out_ready;
    logic        out_px;
    logic [12:0] out_col;
    logic [12:0] out_row;
    logic        busy;
    logic        frame_done;

    always #5 clk = ~clk;

    dilation_stream_ctrl #(
        .PX_PER_ROW     (16'd8),
        .ROWS_PER_FRAME (16'd4)
    ) dut (
        .CLK100MHZ  (clk),
        .btn_reset  (rst),
        .start      (start),
        .in_valid   (in_valid),
        .in_px      (in_px),
        .in_ready   (in_ready),
        .kernel_px  (kernel_px),
        .win_px     (win_px),
        .win_ena    (win_ena),
        .win_reset  (win_reset),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_px     (out_px),
        .out_col    (out_col),
        .out_row    (out_row),
        .busy       (busy),
        .frame_done (frame_done)
    );

    // Window datapath stand-in: two linear row buffers plus taps; sr[j] holds pixel k-1-j.
    logic [2*W+1:0] sr;
    always @(posedge clk) begin
        if (win_reset)    sr <= '0;
        else if (win_ena) sr <= {sr[2*W:0], win_px};
    end
    assign kernel_px = win_px | sr[0] | sr[1] | sr[W-1] | sr[W] | sr[W+1]
                     | sr[2*W-1] | sr[2*W] | sr[2*W+1];

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    typedef struct {
        bit px;
        int row;
        int col;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   done_cnt  = 0;
    bit   chk_done  = 0;
    bit   got_first = 0;
    int   prime_cnt = 0;

    always @(negedge clk) begin
        if (rst) begin
            sb.delete();
            chk_done  = 0;
            got_first = 0;
            prime_cnt = 0;
        end else begin
            if (chk_done) begin
                check("frame_done_after_last", int'(frame_done), 1);
                chk_done = 0;
            end
            if (frame_done) done_cnt++;
            if (out_valid && !out_ready) check("no_adv_while_stalled", int'(win_ena), 0);
            if (!busy) begin
                got_first = 0;
                prime_cnt = 0;
            end else if (!got_first) begin
                if (out_valid) begin
                    got_first = 1;
                    // The advance that loads the first result is counted too.
                    check("priming_advances", prime_cnt - 1, W + 1);
                end else if (win_ena) begin
                    prime_cnt++;
                end
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL extra_output: got row %0d col %0d px %0d, expected none",
                             out_row, out_col, out_px);
                end else begin
                    mon_e = sb.pop_front();
                    check("out_px",  int'(out_px),  int'(mon_e.px));
                    check("out_row", int'(out_row), mon_e.row);
                    check("out_col", int'(out_col), mon_e.col);
                    if (sb.size() == 0) chk_done = 1;
                end
            end
        end
    end

    bit stall_mode = 0;
    bit gap_mode   = 0;

    initial begin : ready_drv
        int ph;
        ph = 0;
        out_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (stall_mode) begin
                out_ready = (ph == 0) || (ph == 3);
                ph = (ph + 1) % 4;
            end else begin
                out_ready = 1'b1;
            end
        end
    end

    bit img [N];

    task automatic push_expected();
        for (int p = 0; p < N; p++) begin
            exp_t e;
            bit   v;
            int   r;
            int   c;
            v = 0;
            r = p / W;
            c = p % W;
            for (int dr = -1; dr <= 1; dr++) begin
                for (int dc = -1; dc <= 1; dc++) begin
                    int q;
                    q = p + dr * W + dc;
                    if (q >= 0 && q < N && img[q]) v = 1;
                end
            end
`ifdef DIL_BORDER_MASK_EN
            if (r == 0 || r == H - 1 || c == 0 || c == W - 1) v = 0;
`endif
            e.px  = v;
            e.row = r;
            e.col = c;
            sb.push_back(e);
        end
    endtask

    task automatic fill_random();
        for (int i = 0; i < N; i++) img[i] = ($urandom_range(0, 4) == 0);
    endtask

    task automatic run_frame(input int abort_after, input bit hold_start);
        int idx;
        int budget;
        int d0;
        bit acc;
        idx    = 0;
        budget = 0;
        d0     = done_cnt;
        push_expected();
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = hold_start;
        while (idx < N) begin
            in_valid = gap_mode ? ($urandom_range(0, 2) != 0) : 1'b1;
            in_px    = img[idx];
            @(negedge clk);
            acc = in_valid && in_ready;
            @(posedge clk); #1;
            if (acc) idx++;
            if (acc && idx == abort_after) begin
                rst = 1'b1; in_valid = 1'b0; start = 1'b0;
                #1;
                check("abort_out_valid", int'(out_valid), 0);
                check("abort_win_reset", int'(win_reset), 1);
                check("abort_busy",      int'(busy),      0);
                check("abort_in_ready",  int'(in_ready),  0);
                @(negedge clk);
                @(posedge clk); #1;
                rst = 1'b0;
                @(posedge clk); #1;
                check("abort_no_frame_done", done_cnt - d0, 0);
                return;
            end
            budget++;
            if (budget > 1000) begin
                check("input_accept_timeout", idx, N);
                break;
            end
        end
        in_valid = 1'b0;
        in_px    = 1'b0;
        budget   = 0;
        while (!frame_done && budget < 1000) begin
            @(posedge clk); #1;
            budget++;
        end
        start = 1'b0;
        check("frame_done_seen", int'(frame_done), 1);
        repeat (3) @(posedge clk);
        #1;
        check("frame_done_count", done_cnt - d0, 1);
        check("scoreboard_drained", sb.size(), 0);
        check("idle_after_frame", int'(busy), 0);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_px = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_out_valid",  int'(out_valid),  0);
        check("rst_out_px",     int'(out_px),     0);
        check("rst_out_col",    int'(out_col),    0);
        check("rst_out_row",    int'(out_row),    0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_in_ready",   int'(in_ready),   0);
        check("rst_win_ena",    int'(win_ena),    0);
        check("rst_win_reset",  int'(win_reset),  1);
        check("rst_busy",       int'(busy),       0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < N; i++) img[i] = 0;
        run_frame(0, 0);

        img[2 * W + 1] = 1;
        run_frame(0, 0);

        stall_mode = 1; gap_mode = 1;
        run_frame(0, 0);
        for (int f = 0; f < 3; f++) begin
            fill_random();
            run_frame(0, 0);
        end

        stall_mode = 0; gap_mode = 0;
        fill_random();
        run_frame(20, 0);
        fill_random();
        run_frame(0, 0);

        stall_mode = 1; gap_mode = 1;
        fill_random();
        run_frame(0, 1);
        stall_mode = 0; gap_mode = 0;
        fill_random();
        run_frame(0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/dilation_stream_ctrl.md
# dilation_stream_ctrl

Frame sequencer for the 3x3 binary dilation window that sits between the Sobel edge stage and the display/frame-buffer writer. It accepts a valid/ready pixel stream, drives the window's enable and clear lines, and flushes the two row buffers at end of frame. It realigns the delayed kernel result into a valid/ready output stream tagged with row/column coordinates, and pulses a done strobe per frame.

## Interface
- `PX_PER_ROW`, 16'd520, image width W in pixels (≥4)
- `ROWS_PER_FRAME`, 16'd390, image height H in rows (≥3)
- `CLK100MHZ`  in  1  system clock, all logic on rising edge
- `btn_reset`  in  1  asynchronous, active-high reset
- `start`  in  1  begin a frame; sampled only in IDLE
- `in_valid`  in  1  upstream pixel available
- `in_px`  in  1  upstream binary pixel
- `in_ready`  out  1  pixel accepted this cycle when `in_valid & in_ready`
- `kernel_px`  in  1  combinational dilation result from window datapath
- `win_px`  out  1  pixel fed to window (`in_px` in RUN, 0 in FLUSH)
- `win_ena`  out  1  window advance strobe
- `win_reset`  out  1  synchronous clear to window buffers
- `out_valid`  out  1  `out_px` holds a result
- `out_ready`  in  1  downstream accepts
- `out_px`  out  1  dilated pixel
- `out_col`  out  13  column of `out_px`
- `out_row`  out  13  row of `out_px`
- `busy`  out  1  high in RUN/FLUSH/DONE
- `frame_done`  out  1  one-cycle pulse after last output accepted

## Operation
- States: IDLE, RUN, FLUSH, DONE.
- IDLE: `win_reset`=1, `in_ready`=0. `start`=1 → RUN, clear feed counter `fed`, `out_col`, `out_row`.
- Output slot free: `free = !out_valid | out_ready`.
- Advance: `adv = free & ((RUN & in_valid) | FLUSH)`. `win_ena = adv`. `in_ready = RUN & free`.
- `fed` (20 bits) increments on every `adv`. Advance index k = `fed` before the increment.
- On `adv` with k ≥ W+1: register `out_px <= kernel_px`, set `out_valid`. `kernel_px` during advance k is the result centred on pixel k−(W+1).
- On `adv` with k < W+1 (priming): no output; `out_valid` clears if `out_ready`.
- Coordinates advance when `out_valid & out_ready`: `out_col` wraps W−1→0 and increments `out_row`.
- RUN → FLUSH when the W·H-th pixel is accepted.
- FLUSH injects W+1 zero pixels (`win_px`=0), producing the final W+1 outputs.
- FLUSH → DONE after advance index W·H+W.
- DONE: wait until the last output handshake completes. Then pulse `frame_done` and → IDLE. `win_reset` is asserted in that transition cycle.
- `start` outside IDLE is ignored.
- Upstream stall (`in_valid`=0 in RUN): no advance, window frozen, output register holds.
- Downstream stall: no advance in either RUN or FLUSH.
- Simultaneous `out_ready` and `adv`: old result is consumed and the new one is loaded in the same edge.

## Timing
- Reset values: state IDLE, `fed`=0, `out_valid`=0, `out_px`=0, `out_col`=0, `out_row`=0, `frame_done`=0.
- Reset values (combinational): `win_ena`=0, `in_ready`=0, `win_reset`=1, `busy`=0.
- `btn_reset` mid-frame: immediate return to IDLE. Partial frame discarded; no `frame_done`.
- Start to first `in_ready`: 1 cycle (IDLE→RUN edge).
- Input-to-output latency: W+1 advances, plus 1 register stage.
- Throughput: 1 pixel/cycle with continuous valid/ready.
- Frame time: W·H+W+1 advance cycles, plus start, plus DONE.
- `win_px`, `win_ena`, `in_ready`, `win_reset`, `busy` are combinational from state and handshakes. All other outputs are registered.

## Configuration
- `DIL_BORDER_MASK_EN` defined: `out_px` is forced to 0 on the image border. Border means `out_col`∈{0,W−1} or `out_row`∈{0,H−1} for the pixel being loaded. This suppresses row-wrap artefacts from the linear row buffers.
- Not defined: `out_px` = `kernel_px` unmodified everywhere.

## Structure
- Shared package `dilation_pkg`:
  - state encoding (2-bit)
  - coordinate width 13
  - feed-counter width 20
  - default W/H constants shared with the window datapath
- One sub-module: `dil_coord_counter`, the column/row counter with wrap and enable. It is reused by the border-mask logic.
- FSM, handshake and output register live in the top module.

## Test plan
- W=8, H=4, continuous valid/ready, all-zero image:
  - exactly 32 outputs, all 0
  - last output at (row 3, col 7)
  - `frame_done` one cycle after the last handshake
  - 8+1 priming advances with `out_valid`=0
- Same setup, single 1 at (row 2, col 1), macro off:
  - nine 1s, at rows 1–3 × cols 0–2
  - all other outputs 0
- Same image, `DIL_BORDER_MASK_EN` on:
  - 1s only at (1,1), (1,2), (2,1), (2,2)
  - border 1s suppressed
- `out_ready` toggled 1,0,0,1 repeating, random `in_valid` gaps:
  - output sequence identical to the unstalled run
  - no pixel lost or duplicated
  - `win_ena` never high while `out_valid & !out_ready`
- `btn_reset` pulsed after 20 accepted pixels:
  - IDLE, `out_valid`=0, `win_reset`=1 immediately
  - a new `start` produces a full, correct 32-pixel frame
- `start` held high during RUN and FLUSH: ignored, exactly one `frame_done`.
